// File: rtl/hc85_seq_cmp.sv
// Sequential wide magnitude comparator driving a single HC85 stage, one nibble
// per clock from the LSB nibble upward, feeding each result back as cascade input.
module hc85_seq_cmp #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_agb,
  output logic                 o_asb,
  output logic                 o_aeb,
  output logic                 o_err,
  output logic [3:0]           o_na,
  output logic [3:0]           o_nb,
  output logic                 o_cagb,
  output logic                 o_casb,
  output logic                 o_caeb,
  input  logic                 i_qagb,
  input  logic                 i_qasb,
  input  logic                 i_qaeb
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2:0]      r_casc;
  logic [2:0]      r_res;
  logic            r_err;
  logic [2:0]      w_q;
  logic            w_accept;
  logic            w_lastRun;

  assign w_q       = {i_qagb, i_qasb, i_qaeb};
  assign w_accept  = (r_state == IDLE) && i_start;
  assign w_lastRun = (r_state == RUN) && (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (r_idx == LAST_IDX) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The result is loaded on the last RUN edge (same value the cascade register
  // takes) so it is already valid while DONE is high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_casc <= 3'b001;
      r_res  <= 3'b000;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= i_a;
            r_b    <= i_b;
            r_idx  <= '0;
            r_casc <= 3'b001;
            r_res  <= 3'b000;
            r_err  <= 1'b0;
          end
        end
        RUN: begin
          r_casc <= w_q;
          r_idx  <= w_lastRun ? '0 : r_idx + 1'b1;
          if (!$onehot(w_q)) r_err <= 1'b1;
          if (w_lastRun) r_res <= w_q;
        end
        FIN: begin
          r_casc <= 3'b001;
        end
        default: begin
          r_casc <= 3'b001;
        end
      endcase
    end
  end

  always_comb begin
    o_busy = (r_state == RUN);
    o_done = (r_state == FIN);
    o_na   = 4'h0;
    o_nb   = 4'h0;
    if (r_state == RUN) begin
      o_na = r_a[{r_idx, 2'b00} +: 4];
      o_nb = r_b[{r_idx, 2'b00} +: 4];
    end
  end

  assign {o_cagb, o_casb, o_caeb} = r_casc;
  assign {o_agb, o_asb, o_aeb}    = r_res;
  assign o_err                    = r_err;

endmodule

// File: tb/tb_hc85_seq_cmp.sv
// Self-checking bench: behavioural HC85 attached to the DUT, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_hc85_seq_cmp;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        stub = 1'b0;
  logic        o_busy, o_done, o_agb, o_asb, o_aeb, o_err;
  logic [3:0]  o_na, o_nb;
  logic        o_cagb, o_casb, o_caeb;
  logic        qagb, qasb, qaeb;

  int checkCnt = 0;
  int passCnt  = 0;
  logic checkEn = 1'b0;

  hc85_seq_cmp #(.NIBBLES(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
    .o_busy(o_busy), .o_done(o_done), .o_agb(o_agb), .o_asb(o_asb),
    .o_aeb(o_aeb), .o_err(o_err), .o_na(o_na), .o_nb(o_nb),
    .o_cagb(o_cagb), .o_casb(o_casb), .o_caeb(o_caeb),
    .i_qagb(qagb), .i_qasb(qasb), .i_qaeb(qaeb)
  );

  always #5 clk = ~clk;

  // Behavioural 74HC85 stage, or a broken stub that always drives 110.
  always_comb begin
    if (stub)               {qagb, qasb, qaeb} = 3'b110;
    else if (o_na > o_nb)   {qagb, qasb, qaeb} = 3'b100;
    else if (o_na < o_nb)   {qagb, qasb, qaeb} = 3'b010;
    else if (o_caeb)        {qagb, qasb, qaeb} = 3'b001;
    else if (o_cagb && o_casb) {qagb, qasb, qaeb} = 3'b000;
    else if (o_cagb)        {qagb, qasb, qaeb} = 3'b100;
    else if (o_casb)        {qagb, qasb, qaeb} = 3'b010;
    else                    {qagb, qasb, qaeb} = 3'b110;
  end

  // Whole-number comparison of the low k nibbles: {gt, lt, eq}.
  function automatic logic [2:0] cmpLow(input logic [15:0] x, input logic [15:0] y, input int k);
    logic [15:0] m;
    m = (k >= 4) ? 16'hFFFF : 16'((32'h1 << (4 * k)) - 32'h1);
    if ((x & m) > (y & m))      return 3'b100;
    else if ((x & m) < (y & m)) return 3'b010;
    else                        return 3'b001;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Transaction model: mCount 0 = idle, 1..N = nibble being compared, N+1 = done cycle.
  int          mCount = 0;
  logic [15:0] mA = '0;
  logic [15:0] mB = '0;
  logic        mStub = 1'b0;
  logic [2:0]  mRes = 3'b000;
  logic        mErr = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCount <= 0;
      mRes   <= 3'b000;
      mErr   <= 1'b0;
    end else if (mCount == 0) begin
      if (start) begin
        mA     <= a;
        mB     <= b;
        mStub  <= stub;
        mCount <= 1;
        mRes   <= 3'b000;
        mErr   <= 1'b0;
      end
    end else if (mCount <= N) begin
      mCount <= mCount + 1;
      if (mStub) mErr <= 1'b1;
      if (mCount == N) mRes <= mStub ? 3'b110 : cmpLow(mA, mB, N);
    end else begin
      mCount <= 0;
    end
  end

  logic       eBusy, eDone;
  logic [3:0] eNa, eNb;
  logic [2:0] eCasc;

  always_comb begin
    eBusy = (mCount >= 1) && (mCount <= N);
    eDone = (mCount == N + 1);
    eNa   = 4'h0;
    eNb   = 4'h0;
    eCasc = 3'b001;
    if (eBusy) begin
      eNa   = 4'(mA >> (4 * (mCount - 1)));
      eNb   = 4'(mB >> (4 * (mCount - 1)));
      eCasc = (mCount == 1) ? 3'b001 : (mStub ? 3'b110 : cmpLow(mA, mB, mCount - 1));
    end else if (eDone) begin
      eCasc = mStub ? 3'b110 : cmpLow(mA, mB, N);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("ctrl",    32'({o_busy, o_done}), 32'({eBusy, eDone}));
      checkOutput("result",  32'({o_agb, o_asb, o_aeb}), 32'(mRes));
      checkOutput("err",     32'(o_err), 32'(mErr));
      checkOutput("nibbles", 32'({o_na, o_nb}), 32'({eNa, eNb}));
      checkOutput("cascade", 32'({o_cagb, o_casb, o_caeb}), 32'(eCasc));
    end
  end

  // One START pulse, then scramble the operands and wait (bounded) for DONE.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                               output int busyCnt, output logic [2:0] res,
                               output logic err, output logic [11:0] trace);
    logic got;
    @(posedge clk); #1;
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    busyCnt = 0; got = 1'b0; res = 3'b000; err = 1'b0; trace = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_busy) begin
        trace = {trace[8:0], o_cagb, o_casb, o_caeb};
        busyCnt++;
      end
      if (o_done) begin
        got = 1'b1;
        res = {o_agb, o_asb, o_aeb};
        err = o_err;
      end
    end
    if (!got) checkOutput("doneTimeout", 32'(0), 32'(1));
  endtask

  int          busyCnt, dones;
  logic [2:0]  res;
  logic        err;
  logic [11:0] trace;
  logic [15:0] ra, rb;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetCtrl", 32'({o_busy, o_done, o_err}), 32'(0));
    checkOutput("resetResult", 32'({o_agb, o_asb, o_aeb}), 32'(0));
    checkOutput("resetNibbles", 32'({o_na, o_nb}), 32'(0));
    checkOutput("resetCascade", 32'({o_cagb, o_casb, o_caeb}), 32'(3'b001));
    @(negedge clk);
    rst = 1'b0;
    checkEn = 1'b1;

    $display("[TB] equal operands");
    applyStimulus(16'h1234, 16'h1234, busyCnt, res, err, trace);
    checkOutput("t1_busyCycles", 32'(busyCnt), 32'(4));
    checkOutput("t1_result", 32'(res), 32'(3'b001));
    checkOutput("t1_err", 32'(err), 32'(0));

    $display("[TB] MSB nibble decides");
    applyStimulus(16'h8000, 16'h7FFF, busyCnt, res, err, trace);
    checkOutput("t2_result", 32'(res), 32'(3'b100));

    applyStimulus(16'h00F0, 16'h00F1, busyCnt, res, err, trace);
    checkOutput("t3_result", 32'(res), 32'(3'b010));
    checkOutput("t3_trace", 32'(trace), 32'(12'b001_010_010_010));
    applyStimulus(16'h00F0, 16'h01F0, busyCnt, res, err, trace);
    checkOutput("t4_result", 32'(res), 32'(3'b010));

    $display("[TB] START held through a run");
    @(posedge clk); #1;
    a = 16'h0042; b = 16'h0041; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_done) dones++;
      @(posedge clk);
    end
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("t5_startInDoneIgnored", 32'(o_busy), 32'(0));
    checkOutput("t5_singleDone", 32'(dones), 32'(1));
    applyStimulus(16'h0001, 16'h0002, busyCnt, res, err, trace);
    checkOutput("t5_nextRun", 32'(res), 32'(3'b010));

    $display("[TB] reset mid-run");
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_ctrl", 32'({o_busy, o_done, o_err}), 32'(0));
    checkOutput("t6_result", 32'({o_agb, o_asb, o_aeb}), 32'(0));
    checkOutput("t6_nibbles", 32'({o_na, o_nb}), 32'(0));
    checkOutput("t6_cascade", 32'({o_cagb, o_casb, o_caeb}), 32'(3'b001));
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    checkOutput("t6_noDone", 32'(dones), 32'(0));
    applyStimulus(16'hFFFF, 16'h0000, busyCnt, res, err, trace);
    checkOutput("t6_afterReset", 32'(res), 32'(3'b100));

    $display("[TB] broken comparator stub");
    stub = 1'b1;
    applyStimulus(16'h1111, 16'h2222, busyCnt, res, err, trace);
    checkOutput("t7_err", 32'(err), 32'(1));
    checkOutput("t7_result", 32'(res), 32'(3'b110));
    stub = 1'b0;
    applyStimulus(16'h1111, 16'h2222, busyCnt, res, err, trace);
    checkOutput("t7_errCleared", 32'(err), 32'(0));

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus(ra, rb, busyCnt, res, err, trace);
    end

    repeat (3) @(posedge clk);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
